// File: rtl/serial_subtractor_3bit_if.sv
// serial_subtractor_3bit_if
//   Handshake/operand bundle for the bit-serial subtractor.
//   master (requester): drives start, a, b; observes busy, done, diff, borrow.
//   slave  (subtractor): the reverse.
//   WIDTH : operand/result width, must match the attached subtractor.
interface serial_subtractor_3bit_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (output start, a, b, input  busy, done, diff, borrow);
  modport slave  (input  start, a, b, output busy, done, diff, borrow);
endinterface

// File: rtl/serial_subtractor_3bit.sv
// serial_subtractor_3bit
//   Bit-serial a - b, LSB first, one bit per clock.
//   Ports:
//     clk         : single clock, rising edge
//     rst         : asynchronous active-high reset
//     bus (slave) : start/a/b request; busy/done/diff/borrow response
//   A start accepted in IDLE or DONE latches a/b; WIDTH SHIFT cycles later the
//   block sits in DONE for one cycle with diff/borrow freshly loaded. diff and
//   borrow are held until the next DONE (or reset).
module serial_subtractor_3bit #(
  parameter int WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_subtractor_3bit_if.slave bus
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_diff_sh;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_br;
  logic [CW-1:0]    r_cnt;

  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_br_nxt;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_diff_nxt;

  // Full-subtractor slice on the current LSBs.
  assign w_ai       = r_a_sh[0];
  assign w_bi       = r_b_sh[0];
  assign w_d        = w_ai ^ w_bi ^ r_br;
  assign w_br_nxt   = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
  assign w_diff_nxt = {w_d, r_diff_sh[WIDTH-1:1]};

  assign w_last   = (r_cnt == LAST);
  // start is only honoured between operations; SHIFT ignores it.
  assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = bus.start ? S_SHIFT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_diff_sh <= '0;
      r_br      <= 1'b0;
      r_cnt     <= '0;
      r_diff    <= '0;
      r_borrow  <= 1'b0;
    end else if (w_accept) begin
      r_a_sh <= bus.a;
      r_b_sh <= bus.b;
      r_br   <= 1'b0;
      r_cnt  <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a_sh    <= r_a_sh >> 1;
      r_b_sh    <= r_b_sh >> 1;
      r_diff_sh <= w_diff_nxt;
      r_br      <= w_br_nxt;
      r_cnt     <= r_cnt + 1'b1;
      // Last bit: publish the completed word on the edge that enters DONE.
      if (w_last) begin
        r_diff   <= w_diff_nxt;
        r_borrow <= w_br_nxt;
      end
    end
  end

  // Status decoded from registered state only.
  assign bus.busy   = (r_state == S_SHIFT);
  assign bus.done   = (r_state == S_DONE);
  assign bus.diff   = r_diff;
  assign bus.borrow = r_borrow;

endmodule
